// File: rtl/layer2_mac_sequencer_pkg.sv
// Shared constants and types for the Layer 2 MAC sequencer.
//   RELU_NODES   : Layer 1 ReLU outputs held by the node queue
//   IN_WIDTH     : unsigned ReLU node value width
//   WEIGHT_WIDTH : two's-complement Layer 2 weight width
//   OUT_NODES    : Layer 2 output neurons
//   INDEX_WIDTH  : node index width
//   ACC_WIDTH    : two's-complement accumulator width
//   state_e      : sequencer state encoding
package layer2_mac_sequencer_pkg;

    localparam int unsigned RELU_NODES   = 100;
    localparam int unsigned IN_WIDTH     = 8;
    localparam int unsigned WEIGHT_WIDTH = 8;
    localparam int unsigned OUT_NODES    = 10;
    localparam int unsigned INDEX_WIDTH  = 7;
    localparam int unsigned ACC_WIDTH    = 24;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StDeq   = 3'd2,
        StCapt  = 3'd3,
        StFetch = 3'd4,
        StMac   = 3'd5,
        StDone  = 3'd6
    } state_e;

    // Smallest accumulator that cannot overflow when every node hits the extreme product.
    function automatic int unsigned min_acc_width(input int unsigned in_w,
                                                  input int unsigned wt_w,
                                                  input int unsigned nodes);
        return in_w + wt_w + $clog2(nodes) + 1;
    endfunction

endpackage

// File: rtl/layer2_mac_sequencer_mac_lane.sv
// One Layer 2 output neuron: signed accumulator plus its multiplier.
//   clk_i    : rising-edge clock
//   reset_i  : synchronous active-high reset, clears the accumulator
//   clear_i  : synchronous clear at the start of a pass
//   en_i     : add value_i * weight_i into the accumulator this cycle
//   value_i  : unsigned node value
//   weight_i : two's-complement weight
//   acc_o    : two's-complement accumulator
module layer2_mac_lane #(
    parameter int unsigned IN_WIDTH     = 8,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned ACC_WIDTH    = 24
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic [IN_WIDTH-1:0]     value_i,
    input  logic [WEIGHT_WIDTH-1:0] weight_i,
    output logic [ACC_WIDTH-1:0]    acc_o
);

    localparam int unsigned ProdWidth = IN_WIDTH + WEIGHT_WIDTH + 1;

    logic signed [ProdWidth-1:0] val_ext;
    logic signed [ProdWidth-1:0] wt_ext;
    logic signed [ProdWidth-1:0] prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] acc_q;

    // Value is unsigned, so it gets a zero sign bit before the signed multiply.
    assign val_ext  = $signed({{(WEIGHT_WIDTH + 1){1'b0}}, value_i});
    assign wt_ext   = $signed({{(IN_WIDTH + 1){weight_i[WEIGHT_WIDTH-1]}}, weight_i});
    assign prod     = val_ext * wt_ext;
    assign prod_ext = $signed({{(ACC_WIDTH - ProdWidth){prod[ProdWidth-1]}}, prod});

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/layer2_mac_sequencer.sv
// Drains the ReLU node queue one node at a time and accumulates each nonzero node's
// weight row into all Layer 2 output neurons in parallel.
//   clk, reset                : clock, synchronous active-high reset
//   start / busy / result_valid : pass control and status
//   queue_write_en, queue_dequeue : queue control (pointer reset, dequeue pulse)
//   queue_index_in/value_in/empty : dequeued node and empty flag
//   weight_addr, weight_rd, weight_row_in : weight row fetch, 1-cycle read latency
//   layer2_out                : packed accumulators, neuron 0 in the MSB slice
module layer2_mac_sequencer #(
    parameter int unsigned RELU_NODES   = layer2_mac_sequencer_pkg::RELU_NODES,
    parameter int unsigned IN_WIDTH     = layer2_mac_sequencer_pkg::IN_WIDTH,
    parameter int unsigned WEIGHT_WIDTH = layer2_mac_sequencer_pkg::WEIGHT_WIDTH,
    parameter int unsigned OUT_NODES    = layer2_mac_sequencer_pkg::OUT_NODES,
    parameter int unsigned INDEX_WIDTH  = layer2_mac_sequencer_pkg::INDEX_WIDTH,
    parameter int unsigned ACC_WIDTH    = layer2_mac_sequencer_pkg::ACC_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    output logic                              busy,
    output logic                              result_valid,
    output logic                              queue_write_en,
    output logic                              queue_dequeue,
    input  logic [INDEX_WIDTH-1:0]            queue_index_in,
    input  logic [IN_WIDTH-1:0]               queue_value_in,
    input  logic                              queue_empty,
    output logic [INDEX_WIDTH-1:0]            weight_addr,
    output logic                              weight_rd,
    input  logic [OUT_NODES*WEIGHT_WIDTH-1:0] weight_row_in,
    output logic [OUT_NODES*ACC_WIDTH-1:0]    layer2_out
);

    import layer2_mac_sequencer_pkg::*;

    if ((ACC_WIDTH < min_acc_width(IN_WIDTH, WEIGHT_WIDTH, RELU_NODES)) ||
        ((2 ** INDEX_WIDTH) < RELU_NODES)) begin : g_param_check
        $error("layer2_mac_sequencer: ACC_WIDTH or INDEX_WIDTH too small");
    end

    state_e                 state_q, state_d;
    logic                   clear_acc;
    logic                   mac_en;
    logic [IN_WIDTH-1:0]    value_q;
    logic                   last_q;
    logic [INDEX_WIDTH-1:0] weight_addr_q;
    logic                   busy_q, result_valid_q, write_en_q, dequeue_q, weight_rd_q;

    always_comb begin
        state_d   = state_q;
        clear_acc = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StLoad;
                    clear_acc = 1'b1;
                end
            end
            StLoad:  state_d = StDeq;
            StDeq:   state_d = StCapt;
            StCapt: begin
                // Zero nodes contribute nothing, so skip the fetch and MAC entirely.
                if (queue_value_in != '0) begin
                    state_d = StFetch;
                end else if (queue_empty) begin
                    state_d = StDone;
                end else begin
                    state_d = StDeq;
                end
            end
            StFetch: state_d = StMac;
            StMac:   state_d = last_q ? StDone : StDeq;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Row data arrives one cycle after the FETCH strobe, i.e. during MAC.
    assign mac_en = (state_q == StMac);

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            value_q        <= '0;
            last_q         <= 1'b0;
            weight_addr_q  <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            write_en_q     <= 1'b0;
            dequeue_q      <= 1'b0;
            weight_rd_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            busy_q         <= (state_d != StIdle) && (state_d != StDone);
            result_valid_q <= (state_d == StDone);
            write_en_q     <= (state_d == StLoad);
            dequeue_q      <= (state_d == StDeq);
            weight_rd_q    <= (state_d == StFetch);
            if (state_q == StCapt) begin
                value_q <= queue_value_in;
                last_q  <= queue_empty;
                // Only nonzero nodes move the address, so it holds outside FETCH.
                if (queue_value_in != '0) begin
                    weight_addr_q <= queue_index_in;
                end
            end
        end
    end

    for (genvar k = 0; k < OUT_NODES; k++) begin : g_lane
        logic [ACC_WIDTH-1:0] lane_acc;

        layer2_mac_lane #(
            .IN_WIDTH     (IN_WIDTH),
            .WEIGHT_WIDTH (WEIGHT_WIDTH),
            .ACC_WIDTH    (ACC_WIDTH)
        ) u_lane (
            .clk_i    (clk),
            .reset_i  (reset),
            .clear_i  (clear_acc),
            .en_i     (mac_en),
            .value_i  (value_q),
            .weight_i (weight_row_in[(OUT_NODES-1-k)*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
            .acc_o    (lane_acc)
        );

        assign layer2_out[(OUT_NODES-1-k)*ACC_WIDTH +: ACC_WIDTH] = lane_acc;
    end

    assign busy           = busy_q;
    assign result_valid   = result_valid_q;
    assign queue_write_en = write_en_q;
    assign queue_dequeue  = dequeue_q;
    assign weight_addr    = weight_addr_q;
    assign weight_rd      = weight_rd_q;

endmodule

// File: tb/tb_layer2_mac_sequencer.sv
// Bench for layer2_mac_sequencer: queue and weight-memory models, table-driven passes,
// reset/start corner sequences and randomized passes against a list-based model.
module tb_layer2_mac_sequencer;
    import layer2_mac_sequencer_pkg::*;

    localparam int unsigned N  = RELU_NODES;
    localparam int unsigned IW = IN_WIDTH;
    localparam int unsigned W  = WEIGHT_WIDTH;
    localparam int unsigned K  = OUT_NODES;
    localparam int unsigned XW = INDEX_WIDTH;
    localparam int unsigned A  = ACC_WIDTH;

    logic            clk = 1'b0;
    logic            reset, start;
    logic            busy, result_valid, queue_write_en, queue_dequeue, weight_rd;
    logic [XW-1:0]   q_index, weight_addr;
    logic [IW-1:0]   q_value;
    logic            q_empty;
    logic [K*W-1:0]  wrow;
    logic [K*A-1:0]  layer2_out;

    always #5 clk = ~clk;

    layer2_mac_sequencer #(
        .RELU_NODES(N), .IN_WIDTH(IW), .WEIGHT_WIDTH(W),
        .OUT_NODES(K), .INDEX_WIDTH(XW), .ACC_WIDTH(A)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .result_valid(result_valid),
        .queue_write_en(queue_write_en), .queue_dequeue(queue_dequeue),
        .queue_index_in(q_index), .queue_value_in(q_value), .queue_empty(q_empty),
        .weight_addr(weight_addr), .weight_rd(weight_rd), .weight_row_in(wrow),
        .layer2_out(layer2_out)
    );

    // Queue contents and weights as plain integers.
    int q_idx[N];
    int q_val[N];
    int q_len = 0;
    int q_ptr = 0;
    int wt[N][K];
    logic [K*W-1:0] wmem[N];

    // Queue: write_en rewinds, each dequeue presents the next node; empty rises with the last.
    initial begin
        q_index = '0; q_value = '0; q_empty = 1'b0; wrow = '0;
    end
    always @(posedge clk) begin
        if (queue_write_en) begin
            q_ptr   <= 0;
            q_empty <= 1'b0;
        end else if (queue_dequeue && q_ptr < q_len) begin
            q_index <= XW'(q_idx[q_ptr]);
            q_value <= IW'(q_val[q_ptr]);
            q_empty <= (q_ptr + 1 == q_len);
            q_ptr   <= q_ptr + 1;
        end
        if (weight_rd) wrow <= wmem[weight_addr];
    end

    // Output monitors, sampled away from the active edge.
    int deq_run, deq_pulses, deq_max, rd_cnt, rv_cnt, wr_cnt;
    int addr_log[$];
    always @(negedge clk) begin
        if (queue_dequeue) begin
            deq_run++;
            if (deq_run == 1) deq_pulses++;
            if (deq_run > deq_max) deq_max = deq_run;
        end else begin
            deq_run = 0;
        end
        if (weight_rd) begin
            rd_cnt++;
            addr_log.push_back(int'(weight_addr));
        end
        if (result_valid) rv_cnt++;
        if (queue_write_en) wr_cnt++;
    end

    task automatic clear_mon();
        deq_run = 0; deq_pulses = 0; deq_max = 0; rd_cnt = 0; rv_cnt = 0; wr_cnt = 0;
        addr_log.delete();
    endtask

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int get_acc(input int k);
        logic [A-1:0] s;
        s = layer2_out[(K-1-k)*A +: A];
        return int'($signed(s));
    endfunction

    // Reference model: straight sum over the queue contents.
    int exp_acc[K];
    int exp_lat;
    int exp_addr[$];

    task automatic build_model();
        int nnz;
        nnz = 0;
        exp_addr.delete();
        for (int k = 0; k < K; k++) exp_acc[k] = 0;
        for (int i = 0; i < q_len; i++) begin
            if (q_val[i] != 0) begin
                nnz++;
                exp_addr.push_back(q_idx[i]);
                for (int k = 0; k < K; k++) exp_acc[k] += q_val[i] * wt[q_idx[i]][k];
            end
        end
        exp_lat = 2 + 4 * nnz + 2 * (q_len - nnz) + 1;
        for (int i = 0; i < int'(N); i++) begin
            for (int k = 0; k < K; k++) begin
                logic [W-1:0] b;
                b = wt[i][k][W-1:0];
                wmem[i][(K-1-k)*W +: W] = b;
            end
        end
    endtask

    task automatic fill(input int vp, input int wp);
        q_len = N;
        for (int i = 0; i < int'(N); i++) begin
            q_idx[i] = i;
            case (vp)
                0: q_val[i] = 1;
                1: q_val[i] = (i % 2 == 1) ? 3 : 0;
                2: q_val[i] = 255;
                default: q_val[i] = 0;
            endcase
            for (int k = 0; k < K; k++) begin
                case (wp)
                    0: wt[i][k] = k - 5;
                    1: wt[i][k] = 2;
                    default: wt[i][k] = -128;
                endcase
            end
        end
        build_model();
    endtask

    // Latency counts the start cycle through the result_valid cycle inclusive.
    task automatic run_pass(input bit hold, output int lat, output bit to);
        int n;
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        n  = 0;
        to = 1'b0;
        forever begin
            @(negedge clk);
            n++;
            if (result_valid) break;
            if (n > 3000) begin
                to = 1'b1;
                break;
            end
        end
        lat = n + 1;
        if (hold) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_pass(input string name, input int lat, input bit to);
        int bad;
        check({name, " timeout"}, int'(to), 0);
        check({name, " latency"}, lat, exp_lat);
        check({name, " result_valid pulses"}, rv_cnt, 1);
        check({name, " write_en pulses"}, wr_cnt, 1);
        check({name, " dequeue pulses"}, deq_pulses, q_len);
        check({name, " dequeue max width"}, deq_max, 1);
        check({name, " weight_rd pulses"}, rd_cnt, exp_addr.size());
        bad = 0;
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i >= addr_log.size() || addr_log[i] != exp_addr[i]) bad++;
        end
        check({name, " weight_addr order errors"}, bad, 0);
        for (int k = 0; k < K; k++) check($sformatf("%s neuron %0d", name, k), get_acc(k),
                                          exp_acc[k]);
    endtask

    typedef struct {
        int vp;
        int wp;
        int lat;
        int n0;
        int n9;
        int rd;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   lat;
        bit   to;
        int   fetches;
        int   n;
        int   nz;

        tbl[0] = '{vp: 0, wp: 0, lat: 403, n0: -500,     n9: 400,      rd: 100};
        tbl[1] = '{vp: 1, wp: 1, lat: 303, n0: 300,      n9: 300,      rd: 50};
        tbl[2] = '{vp: 2, wp: 2, lat: 403, n0: -3264000, n9: -3264000, rd: 100};
        tbl[3] = '{vp: 3, wp: 0, lat: 203, n0: 0,        n9: 0,        rd: 0};

        reset = 1'b1;
        start = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset result_valid", int'(result_valid), 0);
        check("reset write_en", int'(queue_write_en), 0);
        check("reset dequeue", int'(queue_dequeue), 0);
        check("reset weight_rd", int'(weight_rd), 0);
        check("reset weight_addr", int'(weight_addr), 0);
        check("reset layer2_out nonzero", int'(layer2_out != '0), 0);

        for (int t = 0; t < 4; t++) begin
            fill(tbl[t].vp, tbl[t].wp);
            run_pass(1'b0, lat, to);
            check($sformatf("table %0d latency const", t), lat, tbl[t].lat);
            check($sformatf("table %0d neuron0 const", t), get_acc(0), tbl[t].n0);
            check($sformatf("table %0d neuron9 const", t), get_acc(9), tbl[t].n9);
            check($sformatf("table %0d rd const", t), rd_cnt, tbl[t].rd);
            check_pass($sformatf("table %0d", t), lat, to);
        end

        // Reset during the 37th MAC aborts the pass with everything cleared.
        fill(0, 0);
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        fetches = 0;
        n       = 0;
        while (fetches < 37 && n < 2000) begin
            @(negedge clk);
            n++;
            if (weight_rd) fetches++;
        end
        check("abort reached 37th fetch", fetches, 37);
        @(posedge clk);
        #1;
        check("abort acc before 37th MAC", get_acc(0), -180);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort busy", int'(busy), 0);
        check("abort dequeue", int'(queue_dequeue), 0);
        check("abort weight_rd", int'(weight_rd), 0);
        check("abort write_en", int'(queue_write_en), 0);
        check("abort result_valid", int'(result_valid), 0);
        check("abort layer2_out nonzero", int'(layer2_out != '0), 0);
        clear_mon();
        repeat (10) @(negedge clk);
        check("abort stray result_valid", rv_cnt, 0);
        check("abort stray dequeue", deq_pulses, 0);
        run_pass(1'b0, lat, to);
        check_pass("after abort", lat, to);

        // Start held through the pass and during DONE yields exactly one pass.
        fill(1, 0);
        run_pass(1'b1, lat, to);
        check_pass("start held", lat, to);
        repeat (4) @(negedge clk);
        check("start held no restart", wr_cnt, 1);
        check("start held idle busy", int'(busy), 0);

        // Randomized passes against the model.
        for (int r = 0; r < 6; r++) begin
            q_len = $urandom_range(1, N);
            nz    = $urandom_range(0, 3);
            for (int i = 0; i < q_len; i++) begin
                q_idx[i] = $urandom_range(0, N - 1);
                q_val[i] = ($urandom_range(0, 3) <= nz && nz != 0) ? 0 : $urandom_range(1, 255);
            end
            for (int i = 0; i < int'(N); i++)
                for (int k = 0; k < K; k++) wt[i][k] = int'($urandom_range(0, 255)) - 128;
            build_model();
            run_pass(1'b0, lat, to);
            check_pass($sformatf("random %0d", r), lat, to);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
